// File: rtl/pipelined_sklansky_adder.sv
// Parametrised Sklansky parallel-prefix adder/subtractor with optional registers
// between prefix levels and valid/ready flow control that stalls the whole pipe.
module pipelined_sklansky_adder #(
  parameter int              WIDTH    = 16,
  parameter int              LOG2W    = $clog2(WIDTH),
  parameter logic [LOG2W:0]  REG_MASK = 'b01010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  typedef struct packed {
    logic             vld;
    logic             c0;
    logic             am;
    logic             bm;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
  } stage_t;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  genvar k, i;
  generate
    for (k = 0; k <= LOG2W; k++) begin : lvl
      stage_t d, q;

      if (k == 0) begin : gen_pg
        logic [WIDTH-1:0] be;
        assign be = sub ? ~b : b;
        always_comb begin
          d.vld = in_valid;
          d.c0  = sub | cin;
          d.am  = a[WIDTH-1];
          d.bm  = be[WIDTH-1];
          d.pb  = a ^ be;
          d.gg  = a & be;
          d.pp  = a ^ be;
        end
      end else begin : gen_pfx
        localparam int H = 1 << (k - 1);
        logic [WIDTH-1:0] g_n, p_n;
        for (i = 0; i < WIDTH; i++) begin : gen_bit
          if (((i / H) % 2) == 1) begin : gen_comb
            // partner is the top bit of the lower half of this 2H-wide block
            localparam int J = (i | (H - 1)) & ~H;
            assign g_n[i] = lvl[k-1].q.gg[i] | (lvl[k-1].q.pp[i] & lvl[k-1].q.gg[J]);
            assign p_n[i] = lvl[k-1].q.pp[i] & lvl[k-1].q.pp[J];
          end else begin : gen_pass
            assign g_n[i] = lvl[k-1].q.gg[i];
            assign p_n[i] = lvl[k-1].q.pp[i];
          end
        end
        always_comb begin
          d    = lvl[k-1].q;
          d.gg = g_n;
          d.pp = p_n;
        end
      end

      if (REG_MASK[k]) begin : gen_reg
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n)       q <= '0;
          else if (advance) q <= d;
      end else begin : gen_wire
        assign q = d;
      end
    end
  endgenerate

  stage_t           f;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s_n;

  // c0 acts as the generate of a virtual bit below bit 0
  assign f     = lvl[LOG2W].q;
  assign carry = {f.gg | (f.pp & {WIDTH{f.c0}}), f.c0};
  assign s_n   = f.pb ^ carry[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      out_valid <= f.vld;
      sum       <= s_n;
      cout      <= carry[WIDTH];
      ovf       <= (f.am == f.bm) && (s_n[WIDTH-1] != f.am);
      zero      <= (s_n == '0);
    end

endmodule

// File: tb/tb_pipelined_sklansky_adder.sv
// Bench for pipelined_sklansky_adder: three configurations (16/01010, 32/mask 0,
// 64/all-ones) driven from shared operands with per-instance valid/ready.
module tb_pipelined_sklansky_adder;

  typedef logic [66:0] exp_t;   // {zero, ovf, cout, sum[63:0]}

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] a, b;
  logic        cin, sub;
  logic [2:0]  iv, ir, ov, ordy, co, of, zr;
  logic [15:0] s0;
  logic [31:0] s1;
  logic [63:0] s2;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  pipelined_sklansky_adder #(.WIDTH(16), .REG_MASK(5'b01010)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]),
    .ovf(of[0]), .zero(zr[0]));

  pipelined_sklansky_adder #(.WIDTH(32), .REG_MASK(6'b000000)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[31:0]), .b(b[31:0]),
    .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]),
    .ovf(of[1]), .zero(zr[1]));

  pipelined_sklansky_adder #(.WIDTH(64), .REG_MASK(7'b1111111)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]),
    .ovf(of[2]), .zero(zr[2]));

  function automatic int wd(int d);
    return (d == 0) ? 16 : (d == 1) ? 32 : 64;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? 3 : (d == 1) ? 1 : 8;
  endfunction

  function automatic exp_t act(int d);
    case (d)
      0:       return {zr[0], of[0], co[0], 48'd0, s0};
      1:       return {zr[1], of[1], co[1], 32'd0, s1};
      default: return {zr[2], of[2], co[2], s2};
    endcase
  endfunction

  // Reference: unsigned sum for sum/cout, true signed result range for overflow.
  function automatic exp_t model(int w, logic [63:0] av, logic [63:0] bv, logic ci, logic s);
    logic [64:0]        m, ae, bm, be, full;
    logic signed [65:0] t, sa, sb, r, lim;
    logic [63:0]        sm;
    logic               c, o, z;
    m    = (65'd1 << w) - 65'd1;
    ae   = {1'b0, av} & m;
    bm   = {1'b0, bv} & m;
    be   = s ? (~bm & m) : bm;
    full = ae + be + ((s || ci) ? 65'd1 : 65'd0);
    sm   = full[63:0] & m[63:0];
    c    = |((full >> w) & 65'd1);
    t    = {1'b0, ae} << (66 - w);
    sa   = t >>> (66 - w);
    t    = {1'b0, bm} << (66 - w);
    sb   = t >>> (66 - w);
    if (s) r = sa - sb;
    else begin
      r = sa + sb;
      if (ci) r = r + 66'sd1;
    end
    lim = 66'sd1 <<< (w - 1);
    o   = (r >= lim) || (r < -lim);
    z   = (sm == 64'd0);
    return {z, o, c, sm};
  endfunction

  function automatic void push_exp(int d, exp_t v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
  endfunction

  function automatic exp_t pop_exp(int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void clear_q();
    q0.delete(); q1.delete(); q2.delete();
  endfunction

  task automatic rand_ops();
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) a = '1;
    if ($urandom_range(0, 7) == 0) b = {1'b0, {63{1'b1}}};
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iv = '0; ordy = '0; a = '0; b = '0; cin = 0; sub = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if ({ov[d], act(d)} !== 68'd0) begin
        n_fail++; $display("FAIL reset_state dut%0d: got %h expected 0", d, {ov[d], act(d)});
      end
      n_chk++;
      if (ir[d] !== 1'b1) begin
        n_fail++; $display("FAIL reset_in_ready dut%0d: got %b expected 1", d, ir[d]);
      end
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] va[5], vb[5], es[5];
    logic        vc[5], vs[5], ec[5], eo[5], ez[5];
    int          got[3];
    exp_t        e;
    va = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005};
    vb = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0007};
    vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    es = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'hFFFE};
    ec = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    eo = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ez = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int v = 0; v < 5; v++) begin
      a = {48'd0, va[v]}; b = {48'd0, vb[v]}; cin = vc[v]; sub = vs[v];
      iv = 3'b111; ordy = 3'b111;
      got = '{-1, -1, -1};
      @(posedge clk); #1;
      iv = '0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
        for (int d = 0; d < 3; d++) begin
          if (ov[d] && got[d] < 0) begin
            got[d] = cyc;
            n_chk++;
            if (cyc != lat(d)) begin
              n_fail++; $display("FAIL dir_latency v%0d dut%0d: got %0d expected %0d", v, d, cyc, lat(d));
            end
            e = model(wd(d), {48'd0, va[v]}, {48'd0, vb[v]}, vc[v], vs[v]);
            n_chk++;
            if (act(d) !== e) begin
              n_fail++; $display("FAIL dir_model v%0d dut%0d: got %h expected %h", v, d, act(d), e);
            end
            if (d == 0) begin
              n_chk++;
              if ({zr[0], of[0], co[0], s0} !== {ez[v], eo[v], ec[v], es[v]}) begin
                n_fail++; $display("FAIL dir_const v%0d: got %h expected %h", v,
                                   {zr[0], of[0], co[0], s0}, {ez[v], eo[v], ec[v], es[v]});
              end
            end
          end
        end
        @(posedge clk); #1;
      end
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (got[d] < 0) begin
          n_fail++; $display("FAIL dir_timeout v%0d dut%0d: got no result expected one", v, d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   outs[3];
    exp_t e;
    logic exp_ov;
    outs = '{0, 0, 0};
    clear_q();
    ordy = 3'b111;
    for (int c = 0; c < 112; c++) begin
      rand_ops();
      iv = (c < 100) ? 3'b111 : 3'b000;
      #1;
      for (int d = 0; d < 3; d++) begin
        exp_ov = (c >= lat(d)) && (c < lat(d) + 100);
        n_chk++;
        if (ov[d] !== exp_ov) begin
          n_fail++; $display("FAIL b2b_valid c%0d dut%0d: got %b expected %b", c, d, ov[d], exp_ov);
        end
        if (ov[d] && qsize(d) > 0) begin
          e = pop_exp(d);
          outs[d]++;
          n_chk++;
          if (act(d) !== e) begin
            n_fail++; $display("FAIL b2b_data c%0d dut%0d: got %h expected %h", c, d, act(d), e);
          end
        end
        if (iv[d] && ir[d]) push_exp(d, model(wd(d), a, b, cin, sub));
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (outs[d] != 100) begin
        n_fail++; $display("FAIL b2b_count dut%0d: got %0d expected 100", d, outs[d]);
      end
    end
  endtask

  task automatic test_mid_reset();
    clear_q();
    ordy = 3'b000;
    for (int c = 0; c < 3; c++) begin
      rand_ops();
      iv = 3'b111;
      @(posedge clk); #1;
    end
    iv = '0;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if ({ov[d], act(d)} !== 68'd0) begin
        n_fail++; $display("FAIL midrst_clear dut%0d: got %h expected 0", d, {ov[d], act(d)});
      end
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    ordy = 3'b111;
    for (int c = 0; c < 12; c++) begin
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (ov[d] !== 1'b0) begin
          n_fail++; $display("FAIL midrst_stale c%0d dut%0d: got %b expected 0", c, d, ov[d]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int   acc[3];
    logic stall[3];
    exp_t held[3];
    exp_t e;
    int   cyc;
    acc   = '{0, 0, 0};
    stall = '{1'b0, 1'b0, 1'b0};
    held  = '{'0, '0, '0};
    cyc   = 0;
    clear_q();
    while (!(acc[0] >= 3000 && acc[1] >= 3000 && acc[2] >= 3000 &&
             qsize(0) == 0 && qsize(1) == 0 && qsize(2) == 0)) begin
      if (cyc >= 40000) begin
        n_chk++; n_fail++;
        $display("FAIL rand_timeout: got %0d/%0d/%0d ops expected 3000 each", acc[0], acc[1], acc[2]);
        break;
      end
      rand_ops();
      for (int d = 0; d < 3; d++) begin
        iv[d]   = (acc[d] < 3000) && ($urandom_range(0, 1) == 1);
        ordy[d] = ($urandom_range(0, 99) < 60);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        if (stall[d]) begin
          n_chk++;
          if ({ov[d], act(d)} !== {1'b1, held[d]}) begin
            n_fail++; $display("FAIL rand_stable dut%0d: got %h expected %h", d, {ov[d], act(d)}, {1'b1, held[d]});
          end
        end
        if (ov[d] && ordy[d]) begin
          n_chk++;
          if (qsize(d) == 0) begin
            n_fail++; $display("FAIL rand_extra dut%0d: got result %h expected none", d, act(d));
          end else begin
            e = pop_exp(d);
            if (act(d) !== e) begin
              n_fail++; $display("FAIL rand_data dut%0d: got %h expected %h", d, act(d), e);
            end
          end
        end
        if (iv[d] && ir[d]) begin
          push_exp(d, model(wd(d), a, b, cin, sub));
          acc[d]++;
        end
        stall[d] = ov[d] && !ordy[d];
        held[d]  = act(d);
      end
      @(posedge clk); #1;
      cyc++;
    end
    iv = '0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
